idct_coef_loader: RTL and testbench

- Upstream feeder for the generated IDCT pipeline.
- Accepts quantised DCT coefficients one per beat on a valid/ready stream and assembles them into 8x8 blocks using two ping-pong banks.
- Drives each completed block as the flat 64-coefficient vector on the IDCT `x` input, holding it stable until the next block.
- Produces a launch strobe and a delayed `out_valid` aligned to the IDCT's fixed pipeline latency, so downstream logic knows which cycle the IDCT `out` vector belongs to a new block.

---
 rtl/idct_coef_loader.sv | 162 ++++++++++++++++
 tb/tb_idct_coef_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_coef_loader.sv
// idct_coef_loader: ping-pong 8x8 block assembler feeding the IDCT x vector.
// Define IDCT_LOADER_ZIGZAG_EN to load coefficients in JPEG zigzag order.
module idct_coef_loader #(
  parameter int WIN          = 12,
  parameter int LATENCY      = 26,
  parameter int MIN_INTERVAL = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIN-1:0]      in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [64*WIN-1:0]   x,
  output logic                x_valid,
  output logic                out_valid,
  output logic [15:0]         blk_count
);

  localparam int GW =
    (MIN_INTERVAL > 1) ? $clog2(MIN_INTERVAL) : 1;
  localparam logic [GW-1:0] GAP_INIT =
    GW'(MIN_INTERVAL - 1);
  localparam bit HAS_GAP = (MIN_INTERVAL > 1);

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL
  } bank_st_e;

  typedef enum logic {
    L_IDLE,
    L_GAP
  } lst_e;

  logic [WIN-1:0]    mem0 [64];
  logic [WIN-1:0]    mem1 [64];
  bank_st_e          bst   [2];
  bank_st_e          bst_n [2];
  logic              wr_bank;
  logic              rd_bank;
  logic [5:0]        wr_idx;
  logic [5:0]        wr_pos;
  logic              live;
  logic              acc;
  logic              launch;
  lst_e              lst;
  lst_e              lst_n;
  logic [GW-1:0]     gap;
  logic [GW-1:0]     gap_n;
  logic [64*WIN-1:0] x_n;
  logic [LATENCY-1:0] vsr;

`ifdef IDCT_LOADER_ZIGZAG_EN
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16,
    6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25,
    6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33,
    6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,
    6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56,
    6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23,
    6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45,
    6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54,
    6'd47, 6'd55, 6'd62, 6'd63
  };
  assign wr_pos = ZZ[wr_idx];
`else
  assign wr_pos = wr_idx;
`endif

  // ready depends only on registered state, never on this cycle's launch
  assign in_ready  = live && (bst[wr_bank] != B_FULL);
  assign acc       = in_valid && in_ready;
  assign out_valid = vsr[LATENCY-1];

  always_ff @(posedge clk) begin
    if (acc && !wr_bank) mem0[wr_pos] <= in_data;
    if (acc &&  wr_bank) mem1[wr_pos] <= in_data;
  end

  always_comb begin
    x_n = '0;
    for (int i = 0; i < 64; i++) begin
      x_n[i*WIN +: WIN] = rd_bank ? mem1[i]
                                  : mem0[i];
    end
  end

  always_comb begin
    lst_n  = lst;
    gap_n  = gap;
    launch = 1'b0;
    unique case (lst)
      L_IDLE: begin
        if (bst[rd_bank] == B_FULL &&
            gap == '0) begin
          launch = 1'b1;
          gap_n  = GAP_INIT;
          lst_n  = HAS_GAP ? L_GAP : L_IDLE;
        end
      end
      L_GAP: begin
        gap_n = gap - GW'(1);
        if (gap == GW'(1)) lst_n = L_IDLE;
      end
      default: lst_n = L_IDLE;
    endcase
  end

  // launch and fill never target the same bank on one edge
  always_comb begin
    bst_n[0] = bst[0];
    bst_n[1] = bst[1];
    if (acc) begin
      bst_n[wr_bank] = (wr_idx == 6'd63) ? B_FULL
                                         : B_FILLING;
    end
    if (launch) bst_n[rd_bank] = B_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live      <= 1'b0;
      bst[0]    <= B_EMPTY;
      bst[1]    <= B_EMPTY;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= 6'd0;
      lst       <= L_IDLE;
      gap       <= '0;
      x         <= '0;
      x_valid   <= 1'b0;
      blk_count <= 16'd0;
      vsr       <= '0;
    end else begin
      live    <= 1'b1;
      bst[0]  <= bst_n[0];
      bst[1]  <= bst_n[1];
      lst     <= lst_n;
      gap     <= gap_n;
      x_valid <= launch;
      vsr     <= (vsr << 1) | LATENCY'(x_valid);
      if (acc) begin
        wr_idx <= wr_idx + 6'd1;
        if (wr_idx == 6'd63) wr_bank <= ~wr_bank;
      end
      if (launch) begin
        x         <= x_n;
        rd_bank   <= ~rd_bank;
        blk_count <= blk_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_idct_coef_loader.sv
// tb_idct_coef_loader: directed checks of block assembly, launch pacing,
// output latency and asynchronous reset for idct_coef_loader.
`timescale 1ns/1ps
module tb_idct_coef_loader;

  localparam int WIN = 12;
  localparam int LAT = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [WIN-1:0] in_data  = '0;
  logic           in_valid = 1'b0;
  logic [WIN-1:0] in_data1  = '0;
  logic           in_valid1 = 1'b0;

  logic              in_ready,  in_ready1;
  logic [64*WIN-1:0] x,         x1;
  logic              x_valid,   x_valid1;
  logic              out_valid, out_valid1;
  logic [15:0]       blk_count, blk_count1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  idct_coef_loader #(
    .WIN(WIN), .LATENCY(LAT), .MIN_INTERVAL(64)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x(x),
    .x_valid(x_valid), .out_valid(out_valid),
    .blk_count(blk_count)
  );

  idct_coef_loader #(
    .WIN(WIN), .LATENCY(LAT), .MIN_INTERVAL(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .x(x1),
    .x_valid(x_valid1), .out_valid(out_valid1),
    .blk_count(blk_count1)
  );

`ifdef IDCT_LOADER_ZIGZAG_EN
  int zz [64] = '{
    0, 1, 8, 16, 9, 2, 3, 10,
    17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };
  function automatic int tmap(input int k);
    return zz[k];
  endfunction
`else
  function automatic int tmap(input int k);
    return k;
  endfunction
`endif

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [WIN-1:0] el(
    input logic [64*WIN-1:0] v, input int i);
    return v[i*WIN +: WIN];
  endfunction

  function automatic logic [WIN-1:0] pat(input int b);
    return WIN'(b * 37 + 5);
  endfunction

  function automatic logic [WIN-1:0] pat3(input int b);
    return WIN'(b ^ 12'ha5a);
  endfunction

  // expected raster vector of the reference block
  function automatic logic [WIN-1:0] ref_x(input int i);
    case (i)
      0:       return WIN'(-166);
      1:       return WIN'(-7);
      2:       return WIN'(-4);
      3:       return WIN'(-4);
      8:       return WIN'(-2);
      16:      return WIN'(-2);
      default: return '0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic send(input logic [WIN-1:0] d);
    int w;
    w = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && w < 200) begin
      step();
      w++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  int stream [64];
  int lt [3];
  int nl, b;
  bit acc, bad;

  initial begin
    // reset values before any clock edge
    #2;
    check("rst_x",     32'(x == '0), 1);
    check("rst_xv",    32'(x_valid), 0);
    check("rst_ov",    32'(out_valid), 0);
    check("rst_cnt",   32'(blk_count), 0);
    check("rst_ready", 32'(in_ready), 0);
    step();
    step();
    rst = 1'b0;
    check("ready_pre_edge", 32'(in_ready), 0);
    step();
    check("ready_post_edge", 32'(in_ready), 1);

    // reference block
    for (int k = 0; k < 64; k++) stream[k] = 0;
    stream[0] = -166;
    stream[1] = -7;
`ifdef IDCT_LOADER_ZIGZAG_EN
    stream[2] = -2;
    stream[3] = -2;
    stream[5] = -4;
    stream[6] = -4;
`else
    stream[2] = -4;
    stream[3] = -4;
    stream[8] = -2;
    stream[16] = -2;
`endif
    for (int k = 0; k < 64; k++) send(WIN'(stream[k]));
    check("xv_early", 32'(x_valid), 0);
    step();
    check("xv_launch", 32'(x_valid), 1);
    check("cnt_1", 32'(blk_count), 1);
    bad = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (el(x, i) !== ref_x(i)) bad = 1'b1;
    end
    check("ref_x_all", 32'(bad), 0);
    check("ref_x0", 32'(el(x, 0)), 32'(ref_x(0)));
    check("ref_x1", 32'(el(x, 1)), 32'(ref_x(1)));
    check("ref_x8", 32'(el(x, 8)), 32'(ref_x(8)));
    check("ref_x16", 32'(el(x, 16)), 32'(ref_x(16)));
    bad = 1'b0;
    for (int c = 0; c < LAT - 1; c++) begin
      step();
      if (out_valid) bad = 1'b1;
      if (x_valid) bad = 1'b1;
    end
    check("ov_early", 32'(bad), 0);
    step();
    check("ov_pulse", 32'(out_valid), 1);
    step();
    check("ov_one_cycle", 32'(out_valid), 0);
    check("x_held", 32'(el(x, 0)), 32'(ref_x(0)));

    // continuous stream into the 64-cycle pacing instance
    do_reset();
    b  = 0;
    nl = 0;
    for (int c = 0; c < 400 && nl < 3; c++) begin
      in_valid = (b < 200);
      in_data  = pat(b);
      acc      = in_valid && in_ready;
      step();
      if (acc) b++;
      if (x_valid) begin
        lt[nl] = c;
        nl++;
      end
    end
    in_valid = 1'b0;
    check("bp_launches", 32'(nl), 3);
    check("bp_first", 32'(lt[0]), 64);
    check("bp_gap1", 32'(lt[1] - lt[0]), 64);
    check("bp_gap2", 32'(lt[2] - lt[1]), 64);
    check("bp_cnt", 32'(blk_count), 3);
    check("bp_b3_k0", 32'(el(x, tmap(0))), 32'(pat(128)));
    check("bp_b3_k37", 32'(el(x, tmap(37))), 32'(pat(165)));
    check("bp_b3_k63", 32'(el(x, tmap(63))), 32'(pat(191)));

    // back-to-back capable instance
    do_reset();
    b   = 0;
    nl  = 0;
    bad = 1'b0;
    for (int c = 0; c < 300 && nl < 3; c++) begin
      in_valid1 = (b < 192);
      in_data1  = pat(b);
      if (!in_ready1) bad = 1'b1;
      acc = in_valid1 && in_ready1;
      step();
      if (acc) b++;
      if (x_valid1) begin
        lt[nl] = c;
        nl++;
      end
    end
    in_valid1 = 1'b0;
    check("mi1_ready_drop", 32'(bad), 0);
    check("mi1_launches", 32'(nl), 3);
    check("mi1_gap1", 32'(lt[1] - lt[0]), 64);
    check("mi1_gap2", 32'(lt[2] - lt[1]), 64);
    check("mi1_cnt", 32'(blk_count1), 3);
    check("mi1_b3_k5", 32'(el(x1, tmap(5))), 32'(pat(133)));

    // reset with one block in flight and another half loaded
    do_reset();
    for (int k = 0; k < 64; k++) send(WIN'(k + 100));
    step();
    check("mr_launch", 32'(x_valid), 1);
    for (int k = 0; k < 10; k++) send(WIN'(k + 900));
    #2 rst = 1'b1;
    #1;
    check("mr_x",     32'(x == '0), 1);
    check("mr_xv",    32'(x_valid), 0);
    check("mr_ov",    32'(out_valid), 0);
    check("mr_cnt",   32'(blk_count), 0);
    check("mr_ready", 32'(in_ready), 0);
    step();
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (out_valid || x_valid) bad = 1'b1;
    end
    check("mr_no_ov", 32'(bad), 0);
    for (int k = 0; k < 64; k++) send(pat3(k));
    step();
    check("mr_new_launch", 32'(x_valid), 1);
    check("mr_new_cnt", 32'(blk_count), 1);
    bad = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (el(x, tmap(k)) !== pat3(k)) bad = 1'b1;
    end
    check("mr_new_x_all", 32'(bad), 0);
    check("mr_new_x0", 32'(el(x, tmap(0))), 32'(pat3(0)));

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
